interrupt_controller: RTL and testbench

Memory-mapped interrupt controller between the peripheral modules and the CPU's `int`/`int_ack` pair. It sits in the arbiter's address space.
- Edge-detects up to NUM_SRC peripheral interrupt lines (UART rx, timer, button, GPIO, …) and latches them as pending bits.
- Applies a per-source mask and a global enable, and raises a single `int` request to the CPU.
- On `int_ack`, records the winning source vector and disables further interrupts until software re-enables them.

---
 rtl/interrupt_controller_pkg.sv | 20 ++
 rtl/intc_prio_enc.sv | 21 ++
 rtl/interrupt_controller.sv | 123 ++++++++++++
 tb/tb_interrupt_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller: register map, FSM encoding
// and GIE bit position, for use by the arbiter decode and software headers.
package interrupt_controller_pkg;

    typedef logic [1:0] reg_addr_t;

    localparam reg_addr_t ADDR_MASK   = 2'd0;
    localparam reg_addr_t ADDR_STATUS = 2'd1;
    localparam reg_addr_t ADDR_VECTOR = 2'd2;
    localparam reg_addr_t ADDR_RSVD   = 2'd3;

    localparam int GIE_BIT = 0;

    // Wide enough for source numbers 1..31
    localparam int VEC_W = 5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-wins priority encoder: returns index+1 of the lowest set bit,
// or 0 when no bit is set.
module intc_prio_enc
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] active_i,
    output logic [VEC_W-1:0]   vec_o
);

    always_comb begin
        vec_o = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active_i[i]) begin
                vec_o = VEC_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller: edge-detected pending bits, per-source
// mask with global enable, single registered request to the CPU.
//
// state | meaning
// IDLE  | no request to the CPU
// REQ   | int_o asserted, waiting for int_ack_i or loss of GIE/active
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic               sel_i,
    input  logic               we_i,
    input  logic [1:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    output logic               int_o,
    input  logic               int_ack_i
);

    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC:0]   mask_q, mask_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [0:0]         state_q, state_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] act_vec;
    logic [VEC_W-1:0]   winner;
    logic               gie;
    logic               active;
    logic               wr_mask;
    logic               wr_status;

    assign rise      = irq_src_i & ~prev_q;
    assign act_vec   = pend_q & mask_q[NUM_SRC:1];
    assign gie       = mask_q[GIE_BIT];
    assign active    = |act_vec;
    assign wr_mask   = sel_i & we_i & (addr_i == ADDR_MASK);
    assign wr_status = sel_i & we_i & (addr_i == ADDR_STATUS);
    assign int_o     = (state_q == ST_REQ);

    intc_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .active_i (act_vec),
        .vec_o    (winner)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        mask_d  = mask_q;
        pend_d  = pend_q;

        if (wr_mask) begin
            mask_d = wdata_i[NUM_SRC:0];
        end

        // A new edge wins over a same-cycle write-1-to-clear
        if (wr_status) begin
            pend_d = pend_q & ~wdata_i[NUM_SRC:1];
        end
        pend_d = pend_d | rise;

        case (state_q)
            ST_IDLE: begin
                if (gie & active) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (int_ack_i) begin
                    vec_d           = winner;
                    mask_d[GIE_BIT] = 1'b0;
                    state_d         = ST_IDLE;
                end else if (!(gie & active)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q  <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            vec_q   <= '0;
            state_q <= ST_IDLE;
        end else begin
            prev_q  <= irq_src_i;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            vec_q   <= vec_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (sel_i) begin
            case (addr_i)
                ADDR_MASK:   rdata_o[NUM_SRC:0]  = mask_q;
                ADDR_STATUS: rdata_o[NUM_SRC:1]  = pend_q;
                ADDR_VECTOR: rdata_o[VEC_W-1:0]  = vec_q;
                default:     rdata_o             = '0;
            endcase
        end
    end

    generate
        if (NUM_SRC < 31) begin : g_unused_wdata
            logic unused_wdata;
            assign unused_wdata = ^wdata_i[31:NUM_SRC+1];
        end
    endgenerate

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with a register-image reference
// model compared every cycle, plus literal expectations from the test plan.
`timescale 1ns/100ps
module tb_interrupt_controller;

    localparam int NUM_SRC = 8;
    localparam logic [31:0] MASKBITS = (32'd1 << (NUM_SRC + 1)) - 32'd1;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic [NUM_SRC-1:0] irq_src_i = '0;
    logic               sel_i = 1'b0;
    logic               we_i = 1'b0;
    logic [1:0]         addr_i = 2'd0;
    logic [31:0]        wdata_i = '0;
    logic [31:0]        rdata_o;
    logic               int_o;
    logic               int_ack_i = 1'b0;

    int checks = 0;
    int errors = 0;

    interrupt_controller #(.NUM_SRC(NUM_SRC)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .irq_src_i (irq_src_i),
        .sel_i     (sel_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .rdata_o   (rdata_o),
        .int_o     (int_o),
        .int_ack_i (int_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: register images as software sees them
    logic [31:0] m_mask, m_pend, m_vec, m_prev;
    logic        m_req;
    logic [31:0] en_pend, rise_img, n_mask, n_pend, n_vec;
    logic        n_req, gie_on, any_act;

    function automatic logic [31:0] lowest_src(input logic [31:0] v);
        for (int i = 1; i <= NUM_SRC; i++) begin
            if (v[i]) return 32'(i);
        end
        return 32'd0;
    endfunction

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return m_mask;
            2'd1:    return m_pend;
            2'd2:    return m_vec;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_mask = 0; m_pend = 0; m_vec = 0; m_prev = 0; m_req = 1'b0;
        end else begin
            en_pend  = m_pend & m_mask & ~32'd1;
            gie_on   = m_mask[0];
            any_act  = (en_pend != 0);
            rise_img = ({24'd0, irq_src_i} & ~m_prev) << 1;
            n_mask = m_mask;
            n_pend = m_pend;
            n_vec  = m_vec;
            if (sel_i && we_i && addr_i == 2'd0) n_mask = wdata_i & MASKBITS;
            if (sel_i && we_i && addr_i == 2'd1) n_pend = m_pend & ~wdata_i;
            n_pend = (n_pend | rise_img) & MASKBITS & ~32'd1;
            if (m_req && int_ack_i) begin
                n_vec  = lowest_src(en_pend);
                n_mask = n_mask & ~32'd1;
                n_req  = 1'b0;
            end else begin
                n_req = gie_on && any_act;
            end
            m_mask = n_mask; m_pend = n_pend; m_vec = n_vec; m_req = n_req;
            m_prev = {24'd0, irq_src_i};
        end
    end

    always @(negedge clk_i) begin
        checks++;
        if (int_o !== m_req) begin
            errors++;
            $display("FAIL model_int: got %0b expected %0b at %0t", int_o, m_req, $time);
        end
        checks++;
        if (rdata_o !== (sel_i ? model_rd(addr_i) : 32'd0)) begin
            errors++;
            $display("FAIL model_rdata: addr %0d got 0x%08h expected 0x%08h at %0t",
                     addr_i, rdata_o, sel_i ? model_rd(addr_i) : 32'd0, $time);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        sel_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
        cyc();
        sel_i = 1'b0; we_i = 1'b0; wdata_i = '0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        sel_i = 1'b1; we_i = 1'b0; addr_i = a;
        #1;
        chk(name, rdata_o, exp);
        sel_i = 1'b0;
    endtask

    task automatic ack();
        int_ack_i = 1'b1;
        cyc();
        int_ack_i = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk("reset_int", {31'd0, int_o}, 32'd0);
        rd_chk("reset_mask", 2'd0, 32'h0);
        rd_chk("reset_status", 2'd1, 32'h0);
        rd_chk("reset_vector", 2'd2, 32'h0);
        cyc();
        rd_chk("reset_rsvd", 2'd3, 32'h0);

        // Masked source still latches
        irq_src_i = 8'h01; cyc(); irq_src_i = 8'h00; cyc();
        rd_chk("masked_status", 2'd1, 32'h2);
        chk("masked_int", {31'd0, int_o}, 32'd0);
        wr(2'd3, 32'hFFFF_FFFF);
        rd_chk("rsvd_after_write", 2'd3, 32'h0);

        // Ack while idle is ignored
        ack();
        rd_chk("idle_ack_vector", 2'd2, 32'h0);
        rd_chk("idle_ack_mask", 2'd0, 32'h0);

        // Basic request / ack, 2-cycle latency
        wr(2'd1, 32'h2);
        wr(2'd0, 32'h3);
        irq_src_i = 8'h01; cyc();
        chk("lat_n1_int", {31'd0, int_o}, 32'd0);
        irq_src_i = 8'h00; cyc();
        chk("lat_n2_int", {31'd0, int_o}, 32'd1);
        ack();
        chk("ack_int", {31'd0, int_o}, 32'd0);
        rd_chk("ack_mask", 2'd0, 32'h2);
        rd_chk("ack_vector", 2'd2, 32'h1);
        rd_chk("ack_keeps_pending", 2'd1, 32'h2);
        wr(2'd1, 32'h2);

        // Two simultaneous sources, priority
        wr(2'd0, 32'hFF);
        irq_src_i = 8'h24; cyc(); irq_src_i = 8'h00; cyc();
        rd_chk("dual_status", 2'd1, 32'h48);
        chk("dual_int", {31'd0, int_o}, 32'd1);
        ack();
        rd_chk("dual_vector1", 2'd2, 32'h3);
        rd_chk("dual_mask", 2'd0, 32'hFE);
        wr(2'd1, 32'h08);
        wr(2'd0, 32'hFF);
        chk("gie_n_int", {31'd0, int_o}, 32'd0);
        cyc();
        chk("gie_n1_int", {31'd0, int_o}, 32'd1);
        ack();
        rd_chk("dual_vector2", 2'd2, 32'h6);
        wr(2'd1, 32'h40);

        // Software masks while in REQ
        wr(2'd0, 32'h3);
        irq_src_i = 8'h01; cyc(); irq_src_i = 8'h00; cyc();
        chk("req_int", {31'd0, int_o}, 32'd1);
        wr(2'd0, 32'h0);
        chk("unmask_n_int", {31'd0, int_o}, 32'd1);
        cyc();
        chk("unmask_n1_int", {31'd0, int_o}, 32'd0);
        rd_chk("unmask_vector", 2'd2, 32'h6);
        rd_chk("unmask_status", 2'd1, 32'h2);

        // Same-cycle edge and W1C: edge wins
        irq_src_i = 8'h01;
        wr(2'd1, 32'h2);
        irq_src_i = 8'h00;
        rd_chk("set_wins_status", 2'd1, 32'h2);
        cyc();

        // Same-cycle ack and MASK write: GIE forced low
        wr(2'd0, 32'h3);
        cyc();
        chk("pre_ackwr_int", {31'd0, int_o}, 32'd1);
        int_ack_i = 1'b1;
        wr(2'd0, 32'h3);
        int_ack_i = 1'b0;
        rd_chk("ackwr_mask", 2'd0, 32'h2);
        rd_chk("ackwr_vector", 2'd2, 32'h1);
        chk("ackwr_int", {31'd0, int_o}, 32'd0);

        // Asynchronous reset mid-REQ, source held high through release
        wr(2'd0, 32'h3);
        cyc();
        chk("pre_rst_int", {31'd0, int_o}, 32'd1);
        #2 rst_i = 1'b1;
        irq_src_i = 8'h01;
        #1 chk("async_rst_int", {31'd0, int_o}, 32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        cyc();
        rd_chk("post_rst_status", 2'd1, 32'h2);
        rd_chk("post_rst_mask", 2'd0, 32'h0);
        rd_chk("post_rst_vector", 2'd2, 32'h0);
        irq_src_i = 8'h00;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
